// File: rtl/chunk_stream_controller_if.sv
// ---------------------------------------------------------------------------
// chunk_stream_controller_if
// Word stream from the chunk controller to the systolic array. One transfer
// carries a packed row of CHUNK lanes plus the tile coordinates and the
// last-row / last-tile flags.
//
// Signals:
//   tpu_data_arr  CHUNK*LANE_W  lane i at [i*LANE_W +: LANE_W], lane 0 leftmost
//   tpu_control   1             word valid
//   tpu_ready     1             array accepts the word at this posedge
//   chunk_row     CR_W          tile row of the current word
//   chunk_col     CC_W          tile column of the current word
//   row_in_chunk  RW_W          row inside the tile
//   last_row      1             word is the bottom row of its tile
//   last_chunk    1             word belongs to the final tile
// Modports: master (controller side), slave (array side).
// ---------------------------------------------------------------------------
interface chunk_stream_controller_if #(
  parameter int MATRIX_W = 8,
  parameter int MATRIX_H = 8,
  parameter int CHUNK    = 4,
  parameter int LANE_W   = 16
);
  localparam int NCR  = (MATRIX_H + CHUNK - 1) / CHUNK;
  localparam int NCC  = (MATRIX_W + CHUNK - 1) / CHUNK;
  localparam int CR_W = (NCR > 1) ? $clog2(NCR) : 1;
  localparam int CC_W = (NCC > 1) ? $clog2(NCC) : 1;
  localparam int RW_W = (CHUNK > 1) ? $clog2(CHUNK) : 1;

  logic [CHUNK*LANE_W-1:0] tpu_data_arr;
  logic                    tpu_control;
  logic                    tpu_ready;
  logic [CR_W-1:0]         chunk_row;
  logic [CC_W-1:0]         chunk_col;
  logic [RW_W-1:0]         row_in_chunk;
  logic                    last_row;
  logic                    last_chunk;

  modport master (
    output tpu_data_arr, tpu_control, chunk_row, chunk_col, row_in_chunk,
           last_row, last_chunk,
    input  tpu_ready
  );

  modport slave (
    input  tpu_data_arr, tpu_control, chunk_row, chunk_col, row_in_chunk,
           last_row, last_chunk,
    output tpu_ready
  );
endinterface

// File: rtl/chunk_stream_controller.sv
// ---------------------------------------------------------------------------
// chunk_stream_controller
// Walks a MATRIX_W x MATRIX_H image stored in a synchronous single-port RAM
// tile by tile (CHUNK x CHUNK) and streams one packed word per tile row to
// the systolic array over a valid/ready handshake. Pixels outside the image
// are delivered as zero lanes, so every tile always has CHUNK full rows.
//
// Ports:
//   clk       clock, all state on posedge
//   reset     asynchronous, active-high; clears all state
//   start     one-cycle request to process the whole image (only when idle)
//   busy      high from the cycle after start is accepted until done
//   done      one-cycle pulse after the final word transfers
//   ram_addr  pixel address row*MATRIX_W+col
//   ram_data  RAM read data, valid one cycle after ram_addr
//   tpu       word stream to the array (master modport)
// ---------------------------------------------------------------------------
module chunk_stream_controller #(
  parameter int MATRIX_W = 8,
  parameter int MATRIX_H = 8,
  parameter int CHUNK    = 4,
  parameter int DATA_W   = 8,
  parameter int LANE_W   = 16,
  localparam int AW = (MATRIX_W * MATRIX_H > 1) ? $clog2(MATRIX_W * MATRIX_H) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [AW-1:0]         ram_addr,
  input  logic [DATA_W-1:0]     ram_data,
  chunk_stream_controller_if.master tpu
);

  localparam int NCR  = (MATRIX_H + CHUNK - 1) / CHUNK;
  localparam int NCC  = (MATRIX_W + CHUNK - 1) / CHUNK;
  localparam int CR_W = (NCR > 1) ? $clog2(NCR) : 1;
  localparam int CC_W = (NCC > 1) ? $clog2(NCC) : 1;
  localparam int RW_W = (CHUNK > 1) ? $clog2(CHUNK) : 1;
  localparam int KW   = $clog2(CHUNK + 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EMIT, S_DONE} state_t;

  state_t                  state;
  logic [KW-1:0]           k;
  logic [CR_W-1:0]         cr;
  logic [CC_W-1:0]         cc;
  logic [RW_W-1:0]         ric;
  logic [CHUNK*LANE_W-1:0] data_q;
  logic                    valid_q;
  logic                    last_row_q;
  logic                    last_chunk_q;

  logic                    last_r, last_c, last_cr, final_word;
  logic [CR_W-1:0]         nxt_cr;
  logic [CC_W-1:0]         nxt_cc;
  logic [RW_W-1:0]         nxt_ric;
  int                      cur_row, nxt_col, adv_row, adv_col;

  function automatic logic pix_ok(input int row, input int col);
    return (row < MATRIX_H) && (col < MATRIX_W);
  endfunction

  function automatic logic [AW-1:0] pix_addr(input int row, input int col);
    return AW'(row * MATRIX_W + col);
  endfunction

  // Counter successors for the word after the current one, and the pixel
  // positions the next RAM address is computed from. The address register
  // always runs one slot ahead of the lane counter because the RAM has a
  // one-cycle read latency.
  always_comb begin
    last_r     = (ric == RW_W'(CHUNK - 1));
    last_c     = (cc == CC_W'(NCC - 1));
    last_cr    = (cr == CR_W'(NCR - 1));
    final_word = last_r && last_c && last_cr;
    nxt_ric    = last_r ? '0 : ric + 1'b1;
    nxt_cc     = cc;
    nxt_cr     = cr;
    if (last_r) begin
      if (last_c) begin
        nxt_cc = '0;
        nxt_cr = cr + 1'b1;
      end else begin
        nxt_cc = cc + 1'b1;
      end
    end
    cur_row = int'(cr) * CHUNK + int'(ric);
    nxt_col = int'(cc) * CHUNK + int'(k) + 1;
    adv_row = int'(nxt_cr) * CHUNK + int'(nxt_ric);
    adv_col = int'(nxt_cc) * CHUNK;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      k            <= '0;
      cr           <= '0;
      cc           <= '0;
      ric          <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      last_row_q   <= 1'b0;
      last_chunk_q <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      ram_addr     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state        <= S_FETCH;
            busy         <= 1'b1;
            k            <= '0;
            cr           <= '0;
            cc           <= '0;
            ric          <= '0;
            last_row_q   <= (CHUNK == 1);
            last_chunk_q <= (NCR == 1) && (NCC == 1);
            ram_addr     <= '0;
          end
        end

        S_FETCH: begin
          // Slot k returns the pixel addressed in slot k-1; pixels outside
          // the image never got an address, so their lane is forced to zero.
          for (int i = 0; i < CHUNK; i++) begin
            if (k == KW'(i + 1)) begin
              data_q[i*LANE_W +: LANE_W] <=
                pix_ok(cur_row, int'(cc) * CHUNK + i) ? LANE_W'(ram_data) : '0;
            end
          end
          if (k == KW'(CHUNK)) begin
            state   <= S_EMIT;
            valid_q <= 1'b1;
          end else begin
            k <= k + 1'b1;
            if ((int'(k) + 1 < CHUNK) && pix_ok(cur_row, nxt_col)) begin
              ram_addr <= pix_addr(cur_row, nxt_col);
            end
          end
        end

        S_EMIT: begin
          if (tpu.tpu_ready) begin
            valid_q <= 1'b0;
            if (final_word) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state        <= S_FETCH;
              k            <= '0;
              cr           <= nxt_cr;
              cc           <= nxt_cc;
              ric          <= nxt_ric;
              last_row_q   <= (nxt_ric == RW_W'(CHUNK - 1));
              last_chunk_q <= (nxt_cr == CR_W'(NCR - 1)) && (nxt_cc == CC_W'(NCC - 1));
              if (pix_ok(adv_row, adv_col)) begin
                ram_addr <= pix_addr(adv_row, adv_col);
              end
            end
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign tpu.tpu_data_arr = data_q;
  assign tpu.tpu_control  = valid_q;
  assign tpu.chunk_row    = cr;
  assign tpu.chunk_col    = cc;
  assign tpu.row_in_chunk = ric;
  assign tpu.last_row     = last_row_q;
  assign tpu.last_chunk   = last_chunk_q;

endmodule

// File: tb/tb_chunk_stream_controller.sv
// ---------------------------------------------------------------------------
// tb_chunk_stream_controller
// Three controller instances (8x8/CHUNK4, 6x6/CHUNK4, 8x8/CHUNK2 with 8-bit
// lanes), each with its own RAM image. One instance is active at a time and
// its outputs are muxed into a common monitor that records transfers and
// checks stall stability; whole passes are compared to an image-level model.
// ---------------------------------------------------------------------------
module tb_chunk_stream_controller;

  typedef struct {
    logic [63:0] data;
    int          cr;
    int          cc;
    int          ric;
    logic        lr;
    logic        lc;
  } xfer_t;

  typedef struct {
    int          s;
    int          idx;
    logic [63:0] data;
    int          cr;
    int          cc;
    int          ric;
    logic        lr;
    logic        lc;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] start_v = 3'b000;
  logic       ready = 1'b1;
  int         sel = 0;
  int         rdy_mode = 0;
  int         cyc = 0;
  logic [7:0] mem [3][64];

  int    errors = 0;
  int    checks = 0;
  xfer_t got[$];
  xfer_t exp_q[$];
  xfer_t hold_x;
  xfer_t cur_x;
  bit    held = 0;
  int    bp_cnt = 0;
  int    first_vld_cyc = -1;
  int    max_addr = 0;
  int    stalls = 0;
  int    done_cnt = 0;
  int    done_cyc = 0;
  vec_t  vecs [16];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // ---------------- DUT 0: 8x8, CHUNK 4, 16-bit lanes ----------------
  chunk_stream_controller_if #(.MATRIX_W(8), .MATRIX_H(8), .CHUNK(4), .LANE_W(16)) if0 ();
  logic busy0, done0;
  logic [5:0] addr0;
  logic [7:0] rd0;
  assign if0.tpu_ready = ready;
  chunk_stream_controller #(.MATRIX_W(8), .MATRIX_H(8), .CHUNK(4), .DATA_W(8), .LANE_W(16)) dut0 (
    .clk(clk), .reset(reset), .start(start_v[0]), .busy(busy0), .done(done0),
    .ram_addr(addr0), .ram_data(rd0), .tpu(if0));

  // ---------------- DUT 1: 6x6, CHUNK 4, 16-bit lanes ----------------
  chunk_stream_controller_if #(.MATRIX_W(6), .MATRIX_H(6), .CHUNK(4), .LANE_W(16)) if1 ();
  logic busy1, done1;
  logic [5:0] addr1;
  logic [7:0] rd1;
  assign if1.tpu_ready = ready;
  chunk_stream_controller #(.MATRIX_W(6), .MATRIX_H(6), .CHUNK(4), .DATA_W(8), .LANE_W(16)) dut1 (
    .clk(clk), .reset(reset), .start(start_v[1]), .busy(busy1), .done(done1),
    .ram_addr(addr1), .ram_data(rd1), .tpu(if1));

  // ---------------- DUT 2: 8x8, CHUNK 2, 8-bit lanes ----------------
  chunk_stream_controller_if #(.MATRIX_W(8), .MATRIX_H(8), .CHUNK(2), .LANE_W(8)) if2 ();
  logic busy2, done2;
  logic [5:0] addr2;
  logic [7:0] rd2;
  assign if2.tpu_ready = ready;
  chunk_stream_controller #(.MATRIX_W(8), .MATRIX_H(8), .CHUNK(2), .DATA_W(8), .LANE_W(8)) dut2 (
    .clk(clk), .reset(reset), .start(start_v[2]), .busy(busy2), .done(done2),
    .ram_addr(addr2), .ram_data(rd2), .tpu(if2));

  // Synchronous single-port RAMs
  always @(posedge clk) begin
    rd0 <= mem[0][addr0];
    rd1 <= mem[1][addr1];
    rd2 <= mem[2][addr2];
  end

  // Active-instance output mux
  logic [63:0] m_data;
  logic [7:0]  m_cr, m_cc, m_ric, m_addr;
  logic        m_valid, m_busy, m_done, m_lr, m_lc;
  always_comb begin
    case (sel)
      1: begin
        m_data = 64'(if1.tpu_data_arr); m_valid = if1.tpu_control;
        m_cr = 8'(if1.chunk_row); m_cc = 8'(if1.chunk_col); m_ric = 8'(if1.row_in_chunk);
        m_lr = if1.last_row; m_lc = if1.last_chunk;
        m_busy = busy1; m_done = done1; m_addr = 8'(addr1);
      end
      2: begin
        m_data = 64'(if2.tpu_data_arr); m_valid = if2.tpu_control;
        m_cr = 8'(if2.chunk_row); m_cc = 8'(if2.chunk_col); m_ric = 8'(if2.row_in_chunk);
        m_lr = if2.last_row; m_lc = if2.last_chunk;
        m_busy = busy2; m_done = done2; m_addr = 8'(addr2);
      end
      default: begin
        m_data = 64'(if0.tpu_data_arr); m_valid = if0.tpu_control;
        m_cr = 8'(if0.chunk_row); m_cc = 8'(if0.chunk_col); m_ric = 8'(if0.row_in_chunk);
        m_lr = if0.last_row; m_lc = if0.last_chunk;
        m_busy = busy0; m_done = done0; m_addr = 8'(addr0);
      end
    endcase
  end

  function automatic int cfg_w(input int s);     return (s == 1) ? 6 : 8;  endfunction
  function automatic int cfg_h(input int s);     return (s == 1) ? 6 : 8;  endfunction
  function automatic int cfg_chunk(input int s); return (s == 2) ? 2 : 4;  endfunction
  function automatic int cfg_lane(input int s);  return (s == 2) ? 8 : 16; endfunction

  function automatic bit same_x(input xfer_t a, input xfer_t b);
    return (a.data === b.data) && (a.cr == b.cr) && (a.cc == b.cc) &&
           (a.ric == b.ric) && (a.lr === b.lr) && (a.lc === b.lc);
  endfunction

  // Ready generation and transfer monitor, away from the active edge.
  always @(negedge clk) begin
    case (rdy_mode)
      0: ready = 1'b1;
      1: ready = ($urandom_range(0, 3) != 0);
      2: begin
        ready = !(m_valid && got.size() == 2 && bp_cnt < 3);
        if (!ready) bp_cnt++;
      end
      default: ready = 1'b0;
    endcase
    cur_x.data = m_data; cur_x.cr = int'(m_cr); cur_x.cc = int'(m_cc);
    cur_x.ric = int'(m_ric); cur_x.lr = m_lr; cur_x.lc = m_lc;
    if (held) begin
      if (!reset) begin
        checks++;
        if (!m_valid || !same_x(cur_x, hold_x)) begin
          errors++;
          $display("FAIL stall_hold: got valid=%b data=%h r=%0d, required valid=1 data=%h r=%0d",
                   m_valid, cur_x.data, cur_x.ric, hold_x.data, hold_x.ric);
        end
      end
      held = 0;
    end
    if (m_valid && !reset) begin
      if (first_vld_cyc < 0) first_vld_cyc = cyc;
      if (ready) got.push_back(cur_x);
      else begin held = 1; hold_x = cur_x; stalls++; end
    end
    if (m_busy && int'(m_addr) > max_addr) max_addr = int'(m_addr);
    if (m_done && !reset) begin done_cnt++; done_cyc = cyc; end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Image-level model: the full ordered list of words for one pass.
  task automatic build_exp(input int s);
    int w, h, c, lw, ncr, ncc;
    xfer_t x;
    w = cfg_w(s); h = cfg_h(s); c = cfg_chunk(s); lw = cfg_lane(s);
    ncr = (h + c - 1) / c; ncc = (w + c - 1) / c;
    exp_q.delete();
    for (int r = 0; r < ncr; r++)
      for (int q = 0; q < ncc; q++)
        for (int y = 0; y < c; y++) begin
          x.data = '0;
          for (int i = 0; i < c; i++) begin
            if (r * c + y < h && q * c + i < w)
              x.data = x.data | (64'(mem[s][(r * c + y) * w + q * c + i]) << (i * lw));
          end
          x.cr = r; x.cc = q; x.ric = y;
          x.lr = (y == c - 1);
          x.lc = (r == ncr - 1) && (q == ncc - 1);
          exp_q.push_back(x);
        end
  endtask

  task automatic run_pass(input int s, input int mode, input bit settle, input bit extra_start);
    int t0, budget, d0, c, nw;
    c = cfg_chunk(s);
    sel = s; rdy_mode = mode;
    got.delete(); held = 0; bp_cnt = 0; first_vld_cyc = -1; max_addr = 0; stalls = 0;
    d0 = done_cnt;
    step();
    start_v[s] = 1'b1;
    @(posedge clk);
    step();
    start_v = '0;
    t0 = cyc;
    chk("busy_after_start", m_busy, 1);
    budget = 5000;
    while (done_cnt == d0 && budget > 0) begin
      step();
      budget--;
      start_v[s] = extra_start && (cyc == t0 + 20);
    end
    start_v = '0;
    chk("done_within_budget", budget > 0, 1);
    chk("busy_low_with_done", m_busy, 0);
    build_exp(s);
    nw = exp_q.size();
    chk("first_valid_latency", first_vld_cyc - t0, c + 1);
    chk("done_latency", done_cyc - t0, nw * (c + 2) + stalls);
    if (settle) begin
      repeat (c + 4) step();
      chk("done_pulses", done_cnt - d0, 1);
    end
    chk("word_count", got.size(), nw);
    for (int i = 0; i < nw && i < got.size(); i++) begin
      checks++;
      if (!same_x(got[i], exp_q[i])) begin
        errors++;
        $display("FAIL word[%0d] sel%0d: got %h (%0d,%0d,%0d) lr=%b lc=%b, required %h (%0d,%0d,%0d) lr=%b lc=%b",
                 i, s, got[i].data, got[i].cr, got[i].cc, got[i].ric, got[i].lr, got[i].lc,
                 exp_q[i].data, exp_q[i].cr, exp_q[i].cc, exp_q[i].ric, exp_q[i].lr, exp_q[i].lc);
      end
    end
    chk("addr_inside_image", max_addr < cfg_w(s) * cfg_h(s), 1);
  endtask

  task automatic check_table(input int s);
    xfer_t x;
    for (int j = 0; j < 16; j++) begin
      if (vecs[j].s == s) begin
        x.data = vecs[j].data; x.cr = vecs[j].cr; x.cc = vecs[j].cc;
        x.ric = vecs[j].ric; x.lr = vecs[j].lr; x.lc = vecs[j].lc;
        checks++;
        if (vecs[j].idx >= got.size() || !same_x(got[vecs[j].idx], x)) begin
          errors++;
          if (vecs[j].idx >= got.size())
            $display("FAIL table sel%0d word%0d: got no word, required %h", s, vecs[j].idx, x.data);
          else
            $display("FAIL table sel%0d word%0d: got %h (%0d,%0d,%0d), required %h (%0d,%0d,%0d)",
                     s, vecs[j].idx, got[vecs[j].idx].data, got[vecs[j].idx].cr,
                     got[vecs[j].idx].cc, got[vecs[j].idx].ric, x.data, x.cr, x.cc, x.ric);
        end
      end
    end
  endtask

  initial begin
    int d0, budget;
    for (int s = 0; s < 3; s++)
      for (int i = 0; i < 64; i++) mem[s][i] = 8'(i + 1);

    //          sel idx data                      cr cc r  lr    lc
    vecs[0]  = '{0, 0,  64'h0004_0003_0002_0001, 0, 0, 0, 1'b0, 1'b0};
    vecs[1]  = '{0, 1,  64'h000C_000B_000A_0009, 0, 0, 1, 1'b0, 1'b0};
    vecs[2]  = '{0, 3,  64'h001C_001B_001A_0019, 0, 0, 3, 1'b1, 1'b0};
    vecs[3]  = '{0, 4,  64'h0008_0007_0006_0005, 0, 1, 0, 1'b0, 1'b0};
    vecs[4]  = '{0, 12, 64'h0028_0027_0026_0025, 1, 1, 0, 1'b0, 1'b1};
    vecs[5]  = '{0, 15, 64'h0040_003F_003E_003D, 1, 1, 3, 1'b1, 1'b1};
    vecs[6]  = '{1, 4,  64'h0000_0000_0006_0005, 0, 1, 0, 1'b0, 1'b0};
    vecs[7]  = '{1, 7,  64'h0000_0000_0018_0017, 0, 1, 3, 1'b1, 1'b0};
    vecs[8]  = '{1, 8,  64'h001C_001B_001A_0019, 1, 0, 0, 1'b0, 1'b0};
    vecs[9]  = '{1, 10, 64'h0,                   1, 0, 2, 1'b0, 1'b0};
    vecs[10] = '{1, 11, 64'h0,                   1, 0, 3, 1'b1, 1'b0};
    vecs[11] = '{1, 12, 64'h0000_0000_001E_001D, 1, 1, 0, 1'b0, 1'b1};
    vecs[12] = '{2, 0,  64'h0201,                0, 0, 0, 1'b0, 1'b0};
    vecs[13] = '{2, 1,  64'h0A09,                0, 0, 1, 1'b1, 1'b0};
    vecs[14] = '{2, 2,  64'h0403,                0, 1, 0, 1'b0, 1'b0};
    vecs[15] = '{2, 31, 64'h403F,                3, 3, 1, 1'b1, 1'b1};

    // Reset state
    repeat (2) step();
    chk("reset_data", m_data, 0);
    chk("reset_ctrl", {m_valid, m_busy, m_done, m_lr, m_lc}, 0);
    chk("reset_addr_coord", {m_addr, m_cr, m_cc, m_ric}, 0);
    chk("reset_busy_all", {busy0, busy1, busy2, done0, done1, done2}, 0);
    reset = 1'b0;
    repeat (2) step();

    // Nominal pass, padding pass, narrow-lane pass
    run_pass(0, 0, 1, 0); check_table(0);
    run_pass(1, 0, 1, 0); check_table(1);
    run_pass(2, 0, 1, 0); check_table(2);

    // Three-cycle backpressure on word 2
    run_pass(0, 2, 1, 0); check_table(0);
    chk("bp_stall_cycles", stalls, 3);

    // start while busy is ignored
    run_pass(0, 0, 1, 1); check_table(0);

    // Start in the cycle right after done
    run_pass(0, 0, 0, 0);
    run_pass(0, 0, 1, 0); check_table(0);

    // Asynchronous reset in the middle of EMIT
    sel = 0; rdy_mode = 3;
    step(); start_v[0] = 1'b1;
    step(); start_v = '0;
    budget = 50;
    while (!m_valid && budget > 0) begin step(); budget--; end
    chk("reached_emit", m_valid, 1);
    d0 = done_cnt;
    #2 reset = 1'b1;
    #1;
    chk("areset_data", m_data, 0);
    chk("areset_ctrl", {m_valid, m_busy, m_done, m_lr, m_lc}, 0);
    chk("areset_addr_coord", {m_addr, m_cr, m_cc, m_ric}, 0);
    repeat (2) step();
    reset = 1'b0;
    repeat (10) step();
    chk("no_done_after_reset", done_cnt - d0, 0);
    chk("idle_after_reset", m_busy, 0);
    run_pass(0, 0, 1, 0); check_table(0);

    // Random images with random backpressure
    for (int it = 0; it < 6; it++) begin
      for (int s = 0; s < 3; s++)
        for (int i = 0; i < 64; i++) mem[s][i] = 8'($urandom);
      run_pass(it % 3, 1, 1, it == 4);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
